dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Round-robin arbiter that shares one synchronous data RAM between `NCORES` processing cores of the point-cloud engine. Each core issues single-word read or write requests and stalls until acknowledged. The arbiter serialises the requests onto the single `memREAD`/`memWRITE` RAM port and returns read data to the requesting core. It sits between the core array and the data RAM, replacing the direct core-to-RAM connection.

## Interface
- `WIDTH`, 8: data and address width in bits; RAM depth is 2**WIDTH.
- `NCORES`, 4: number of requesting cores, 2..8.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `core_read`  in  NCORES  per-core read request; bit i is core i.
- `core_write`  in  NCORES  per-core write request.
- `core_addr`  in  NCORES*WIDTH  per-core address; core i occupies bits [i*WIDTH +: WIDTH].
- `core_wdata`  in  NCORES*WIDTH  per-core write data, same packing as `core_addr`.
- `core_rdata`  out  NCORES*WIDTH  per-core registered read data, same packing.
- `core_ack`  out  NCORES  one-cycle completion pulse to the granted core.
- `DRAM_addr`  out  WIDTH  RAM address.
- `DRAM_dataOut`  out  WIDTH  RAM write data.
- `DRAM_dataIn`  in  WIDTH  RAM read data, valid the cycle after the RAM samples `memREAD`.
- `memREAD`  out  1  RAM read strobe.
- `memWRITE`  out  1  RAM write strobe.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  3  index of the current or last granted core.

## Operation
- Core i requests when `core_read[i]` or `core_write[i]` is high.
- If both are high, the request is a write and the read is ignored.
- A core holds its request, address and write data stable until it sees `core_ack[i]`. It drops the request on the edge after the ack cycle.
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
- IDLE
  - If any request is present, select the first requesting core searching `ptr`, `ptr`+1, … mod `NCORES`.
  - Latch the grant index, operation, address and write data.
  - Go to ACCESS. With no request, stay in IDLE.
- ACCESS
  - Drive `DRAM_addr` and, for a write, `DRAM_dataOut`.
  - Assert `memREAD` or `memWRITE` for exactly this one cycle.
  - Next state: CAPTURE for a read, ACK for a write.
- CAPTURE (read only)
  - Strobes low.
  - On the exiting edge, register `DRAM_dataIn` into the granted core's `core_rdata` slice.
  - Next state: ACK.
- ACK
  - `core_ack[grant]` high for exactly this cycle.
  - Set `ptr` = (grant+1) mod `NCORES`.
  - Next state: IDLE.
- `core_rdata` slices of non-granted cores hold their value. A write never changes any `core_rdata` slice.
- Requests that arrive or change while not in IDLE are ignored until the next IDLE sample.
- `core_ack` is one-hot or zero. At most one RAM strobe is high in any cycle.
- All outputs are registered; none depend combinationally on core inputs.

## Timing
- Reset (asynchronous, Rst_n low), immediately:
  - state = IDLE, `ptr` = 0, `grant_id` = 0.
  - All `core_rdata` = 0, `core_ack` = 0.
  - `DRAM_addr` = 0, `DRAM_dataOut` = 0, `memREAD` = 0, `memWRITE` = 0, `busy` = 0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A write whose strobe was already sampled by the RAM stays written. Cores re-request after reset.
- Read, with the request accepted at edge E0:
  - strobe high E0–E1.
  - data captured at E2.
  - ack high E2–E3.
  - IDLE at E3; next acceptance no earlier than E4.
  - 4 cycles per read.
- Write, with the request accepted at E0:
  - `memWRITE` high E0–E1.
  - ack high E1–E2.
  - next acceptance no earlier than E3.
  - 3 cycles per write.
- Fairness: with all `NCORES` requesting continuously, each core is granted once per `NCORES` grants. Worst-case wait is (`NCORES`−1) × 4 cycles plus its own service time.
- `ptr` wrap-around: after a grant to core `NCORES`−1, `ptr` = 0.

## Test plan
- Reset, then core 0 reads address 8'h05 with RAM[5]=8'hAA → `memREAD` for 1 cycle, `DRAM_addr`=8'h05, `core_rdata` slice 0 = 8'hAA, `core_ack`=4'b0001 exactly 2 cycles after acceptance.
- Core 2 writes 8'h3C to 8'h10, then core 2 reads 8'h10 → one `memWRITE` pulse with `DRAM_dataOut`=8'h3C, ack after 1 cycle; the read returns 8'h3C; other `core_rdata` slices unchanged.
- All four cores request reads simultaneously from reset → grant order 0,1,2,3 at 4-cycle spacing; then with cores 0 and 3 still requesting → order 0,3,0,3 (`ptr` wraps correctly).
- Core 1 asserts read and write together with wdata 8'h77 → treated as a write: `memWRITE` only, `memREAD` stays 0, `core_rdata` slice 1 unchanged.
- Assert `Rst_n` low during CAPTURE of a core 3 read → all outputs 0 without waiting for `Clk`, no `core_ack`; after release, core 3 re-request completes normally.
- Random requests over 2000 cycles with a scoreboard RAM model → every read matches the last write to that address; `core_ack` always one-hot or zero; `memREAD` and `memWRITE` never high together.

Source files
------------

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between NCORES cores.
// Single-word read/write requests are serialised onto the memREAD/memWRITE port.
module dram_arbiter #(
    parameter int WIDTH  = 8,
    parameter int NCORES = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NCORES-1:0]       core_read,
    input  logic [NCORES-1:0]       core_write,
    input  logic [NCORES*WIDTH-1:0] core_addr,
    input  logic [NCORES*WIDTH-1:0] core_wdata,
    output logic [NCORES*WIDTH-1:0] core_rdata,
    output logic [NCORES-1:0]       core_ack,
    output logic [WIDTH-1:0]        DRAM_addr,
    output logic [WIDTH-1:0]        DRAM_dataOut,
    input  logic [WIDTH-1:0]        DRAM_dataIn,
    output logic                    memREAD,
    output logic                    memWRITE,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        ACK
    } state_t;

    state_t state, stateNext;

    logic [2:0]              ptr;
    logic [2:0]              grant;
    logic [2:0]              pick;
    logic [2:0]              idx;
    logic                    found;
    logic                    isWrite;
    logic [7:0]              reqPad;
    logic [7:0]              wrPad;
    logic [WIDTH-1:0]        addrQ;
    logic [WIDTH-1:0]        dataQ;
    logic [WIDTH-1:0]        selAddr;
    logic [WIDTH-1:0]        selData;
    logic [NCORES*WIDTH-1:0] rdataQ;

    // Pad request vectors to 8 bits so a 3-bit core index selects cleanly.
    always_comb begin
        reqPad = '0;
        wrPad  = '0;
        reqPad[NCORES-1:0] = core_read | core_write;
        wrPad[NCORES-1:0]  = core_write;
    end

    // First requester searching ptr, ptr+1, ... modulo NCORES.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NCORES; i++) begin
            idx = 3'((32'(ptr) + i) % NCORES);
            if (!found && reqPad[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (pick == 3'(i)) begin
                selAddr = core_addr[i*WIDTH +: WIDTH];
                selData = core_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (found) stateNext = ACCESS;
            ACCESS:  stateNext = isWrite ? ACK : CAPTURE;
            CAPTURE: stateNext = ACK;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            grant   <= '0;
            ptr     <= '0;
            isWrite <= 1'b0;
            addrQ   <= '0;
            dataQ   <= '0;
            rdataQ  <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant   <= pick;
                isWrite <= wrPad[pick];
                addrQ   <= selAddr;
                dataQ   <= wrPad[pick] ? selData : '0;
            end
            if (state == CAPTURE) begin
                for (int i = 0; i < NCORES; i++) begin
                    if (grant == 3'(i)) begin
                        rdataQ[i*WIDTH +: WIDTH] <= DRAM_dataIn;
                    end
                end
            end
            if (state == ACK) begin
                ptr <= (grant == 3'(NCORES-1)) ? '0 : grant + 3'd1;
            end
        end
    end

    // Outputs decode flops only; nothing reaches them from core inputs.
    always_comb begin
        core_ack = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (state == ACK && grant == 3'(i)) begin
                core_ack[i] = 1'b1;
            end
        end
    end

    assign memREAD      = (state == ACCESS) && !isWrite;
    assign memWRITE     = (state == ACCESS) && isWrite;
    assign busy         = (state != IDLE);
    assign grant_id     = grant;
    assign DRAM_addr    = addrQ;
    assign DRAM_dataOut = dataQ;
    assign core_rdata   = rdataQ;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic against a
// transaction-level model with a scoreboard RAM and round-robin predictor.
module tb_dram_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b1;
    logic [N-1:0] core_read;
    logic [N-1:0] core_write;
    logic [N*W-1:0] core_addr;
    logic [N*W-1:0] core_wdata;
    logic [N*W-1:0] core_rdata;
    logic [N-1:0] core_ack;
    logic [W-1:0] DRAM_addr;
    logic [W-1:0] DRAM_dataOut;
    logic [W-1:0] DRAM_dataIn;
    logic         memREAD;
    logic         memWRITE;
    logic         busy;
    logic [2:0]   grant_id;

    dram_arbiter #(.WIDTH(W), .NCORES(N)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .core_read(core_read),
        .core_write(core_write),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_ack(core_ack),
        .DRAM_addr(DRAM_addr),
        .DRAM_dataOut(DRAM_dataOut),
        .DRAM_dataIn(DRAM_dataIn),
        .memREAD(memREAD),
        .memWRITE(memWRITE),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] dflt(logic [7:0] a);
        return (a == 8'h05) ? 8'hAA : (a ^ 8'h5A);
    endfunction

    // Synchronous RAM; unwritten words read back a fixed pattern.
    logic [7:0] ram [256];
    bit         written [256];
    always @(posedge Clk) begin
        if (memWRITE) begin
            ram[DRAM_addr]     <= DRAM_dataOut;
            written[DRAM_addr] <= 1'b1;
        end
        if (memREAD) begin
            DRAM_dataIn <= written[DRAM_addr] ? ram[DRAM_addr] : dflt(DRAM_addr);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]     mMem [256];
    logic [N*W-1:0] mRdata;
    int  mPtr;
    int  cyc;
    bit  accPending;
    int  accCyc;
    int  accCore;
    bit  accWr;
    logic [7:0] accAddr;
    int  grants[$];
    int  accCycles[$];

    function automatic int rrPick(logic [N-1:0] r, int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return 0;
    endfunction

    // One clock: snapshot what the next edge samples, then check the model.
    task automatic step();
        logic [N-1:0] sReq;
        logic [N-1:0] sWr;
        logic [W-1:0] sAddr [N];
        logic [W-1:0] sData [N];
        logic [N-1:0] expAck;
        int d;
        int win;
        sReq = core_read | core_write;
        sWr  = core_write;
        for (int i = 0; i < N; i++) begin
            sAddr[i] = core_addr[i*W +: W];
            sData[i] = core_wdata[i*W +: W];
        end
        @(negedge Clk);
        cyc++;
        if (!Rst_n) begin
            accPending = 1'b0;
            mPtr = 0;
            mRdata = '0;
            chk("rst_outs", 64'({busy, memREAD, memWRITE, core_ack, grant_id}), '0);
            chk("rst_rdata", 64'(core_rdata), 64'(mRdata));
            return;
        end
        chk("ack_onehot0", 64'($onehot0(core_ack)), 64'(1));
        chk("strobe_excl", 64'(memREAD & memWRITE), '0);
        expAck = '0;
        if (!accPending) begin
            if (sReq != '0) begin
                win = rrPick(sReq, mPtr);
                accPending = 1'b1;
                accCyc = cyc;
                accCore = win;
                accWr = sWr[win];
                accAddr = sAddr[win];
                grants.push_back(win);
                accCycles.push_back(cyc);
                chk("accept_busy", 64'(busy), 64'(1));
                chk("grant_id", 64'(grant_id), 64'(win));
                chk("dram_addr", 64'(DRAM_addr), 64'(accAddr));
                chk("memREAD", 64'(memREAD), 64'(!accWr));
                chk("memWRITE", 64'(memWRITE), 64'(accWr));
                if (accWr) begin
                    chk("dram_wdata", 64'(DRAM_dataOut), 64'(sData[win]));
                    mMem[accAddr] = sData[win];
                end
            end else begin
                chk("idle_busy", 64'(busy), '0);
            end
        end else begin
            d = cyc - accCyc;
            chk("strobes_off", 64'({memREAD, memWRITE}), '0);
            if (d == (accWr ? 1 : 2)) begin
                expAck[accCore] = 1'b1;
                if (!accWr) mRdata[accCore*W +: W] = mMem[accAddr];
                mPtr = (accCore + 1) % N;
                core_read[accCore]  = 1'b0;
                core_write[accCore] = 1'b0;
            end
            if (d == (accWr ? 2 : 3)) begin
                chk("done_idle", 64'(busy), '0);
                accPending = 1'b0;
            end else begin
                chk("busy_held", 64'(busy), 64'(1));
            end
        end
        chk("core_ack", 64'(core_ack), 64'(expAck));
        chk("core_rdata", 64'(core_rdata), 64'(mRdata));
    endtask

    task automatic waitIdle(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            step();
            if ((core_read | core_write) == '0 && !accPending) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle", 64'(ok), 64'(1));
    endtask

    task automatic resetDut();
        core_read = '0;
        core_write = '0;
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] saved8;
        logic [23:0] saved24;
        int n0;
        int n3;
        bit found;
        int op;
        for (int a = 0; a < 256; a++) mMem[a] = dflt(8'(a));
        core_read = '0;
        core_write = '0;
        core_addr = '0;
        core_wdata = '0;
        mRdata = '0;
        mPtr = 0;
        cyc = 0;
        accPending = 1'b0;

        #1 Rst_n = 1'b0;
        #1;
        chk("reset_ctl", 64'({busy, memREAD, memWRITE, core_ack, grant_id}), '0);
        chk("reset_dram", 64'({DRAM_addr, DRAM_dataOut}), '0);
        chk("reset_rdata", 64'(core_rdata), '0);
        step();
        step();
        Rst_n = 1'b1;

        // Core 0 reads address 5.
        grants.delete();
        core_read[0] = 1'b1;
        core_addr[0*W +: W] = 8'h05;
        waitIdle(20);
        chk("t1_ngrants", 64'(grants.size()), 64'(1));
        chk("t1_rdata0", 64'(core_rdata[7:0]), 64'(8'hAA));

        // Core 2 writes then reads back.
        saved24 = {core_rdata[31:24], core_rdata[15:0]};
        core_write[2] = 1'b1;
        core_addr[2*W +: W] = 8'h10;
        core_wdata[2*W +: W] = 8'h3C;
        waitIdle(20);
        core_read[2] = 1'b1;
        waitIdle(20);
        chk("t2_rdata2", 64'(core_rdata[23:16]), 64'(8'h3C));
        chk("t2_others", 64'({core_rdata[31:24], core_rdata[15:0]}), 64'(saved24));

        // All four read together from reset, then cores 0 and 3 keep asking.
        resetDut();
        grants.delete();
        accCycles.delete();
        for (int i = 0; i < N; i++) begin
            core_read[i] = 1'b1;
            core_addr[i*W +: W] = 8'(8'h20 + i);
        end
        waitIdle(40);
        chk("t3_ngrants", 64'(grants.size()), 64'(N));
        if (grants.size() == N) begin
            for (int i = 0; i < N; i++) chk("t3_order", 64'(grants[i]), 64'(i));
            for (int i = 1; i < N; i++)
                chk("t3_gap", 64'(accCycles[i] - accCycles[i-1]), 64'(4));
        end
        grants.delete();
        n0 = 0;
        n3 = 0;
        for (int c = 0; c < 60; c++) begin
            if (!core_read[0] && n0 < 2) begin core_read[0] = 1'b1; n0++; end
            if (!core_read[3] && n3 < 2) begin core_read[3] = 1'b1; n3++; end
            if (n0 == 2 && n3 == 2 && core_read == '0 && !accPending) break;
            step();
        end
        chk("t3b_ngrants", 64'(grants.size()), 64'(4));
        if (grants.size() == 4) begin
            chk("t3b_g0", 64'(grants[0]), 64'(0));
            chk("t3b_g1", 64'(grants[1]), 64'(3));
            chk("t3b_g2", 64'(grants[2]), 64'(0));
            chk("t3b_g3", 64'(grants[3]), 64'(3));
        end

        // Read and write together on core 1 is a write.
        saved8 = core_rdata[15:8];
        core_read[1] = 1'b1;
        core_write[1] = 1'b1;
        core_addr[1*W +: W] = 8'h30;
        core_wdata[1*W +: W] = 8'h77;
        waitIdle(20);
        chk("t4_rdata1_hold", 64'(core_rdata[15:8]), 64'(saved8));
        core_read[1] = 1'b1;
        waitIdle(20);
        chk("t4_readback", 64'(core_rdata[15:8]), 64'(8'h77));

        // Asynchronous reset while core 3's read is in CAPTURE.
        core_read[3] = 1'b1;
        core_addr[3*W +: W] = 8'h05;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (accPending && !accWr && (cyc - accCyc) == 1) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_capture_seen", 64'(found), 64'(1));
        #2 Rst_n = 1'b0;
        #1;
        chk("t5_async_ctl", 64'({busy, memREAD, memWRITE, core_ack, grant_id}), '0);
        chk("t5_async_dram", 64'({DRAM_addr, DRAM_dataOut}), '0);
        chk("t5_async_rdata", 64'(core_rdata), '0);
        step();
        step();
        Rst_n = 1'b1;
        grants.delete();
        waitIdle(20);
        chk("t5_ngrants", 64'(grants.size()), 64'(1));
        if (grants.size() == 1) chk("t5_grant", 64'(grants[0]), 64'(3));
        chk("t5_rdata3", 64'(core_rdata[31:24]), 64'(8'hAA));

        // Random traffic over a small address window.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(core_read[i] | core_write[i]) && $urandom_range(0, 3) == 0) begin
                    op = int'($urandom_range(0, 2));
                    core_read[i]  = (op != 1);
                    core_write[i] = (op != 0);
                    core_addr[i*W +: W]  = 8'($urandom_range(0, 15));
                    core_wdata[i*W +: W] = 8'($urandom_range(0, 255));
                end
            end
            step();
        end
        waitIdle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
